icache_ctrl_responder: RTL and testbench
========================================

# icache_ctrl_responder

Cache-side endpoint of the instruction-cache control interface. It receives bypass, full-flush, selective-flush and statistics commands from the cluster-peripheral icache control unit, sequences them against the tag array and per-core fetch units, and returns the matching acknowledges and hit/transaction counts. It sits inside the shared icache, between the control-unit bus and the tag-array invalidation port.

## Interface
- NB_CORES, 8, number of fetching cores
- NB_SETS, 64, tag-array sets (power of 2)
- OFFSET_WIDTH, 4, byte-offset bits of a cache line
- SET_WIDTH, $clog2(NB_SETS), set index width (derived)

- clk_i  in  1  clock
- rst_ni  in  1  reset
- bypass_req_i  in  1  1 = bypass cache, 0 = enable
- bypass_ack_o  out  NB_CORES+1  [i<NB_CORES] per-core bypass state; [NB_CORES] global
- flush_req_i  in  1  full-flush request (level)
- flush_ack_o  out  1  full-flush done
- sel_flush_req_i  in  1  selective-flush request (level)
- sel_flush_addr_i  in  32  address whose set is flushed
- sel_flush_ack_o  out  1  selective-flush done
- clear_regs_i  in  1  clear stat counters (pulse)
- enable_regs_i  in  1  stat counting enable (level)
- hit_count_o  out  32  hit counter
- trans_count_o  out  32  transaction counter
- core_busy_i  in  NB_CORES  core i has an outstanding fetch
- refill_busy_i  in  1  refill engine has an outstanding line fill
- hit_i  in  NB_CORES  per-core hit event this cycle
- trans_i  in  NB_CORES  per-core fetch transaction this cycle
- cache_bypass_o  out  NB_CORES  per-core bypass control to fetch units
- inv_req_o  out  1  invalidate all ways of inv_set_o
- inv_set_o  out  SET_WIDTH  set to invalidate
- inv_gnt_i  in  1  tag array accepted invalidation
- lookup_stall_o  out  1  block tag lookups while flushing

Reset: rst_ni, asynchronous, active-low; clock: clk_i.

## Operation
- Bypass (independent of flush FSM): each cycle, for each core i with core_busy_i[i]=0, bypass_ack_o[i] <= bypass_req_i; busy cores hold. bypass_ack_o[NB_CORES] <= bypass_req_i only when bits [NB_CORES-1:0] all equal bypass_req_i and refill_busy_i=0, else holds. cache_bypass_o = bypass_ack_o[NB_CORES-1:0].
- Flush FSM states: IDLE, FLUSH_WALK, SEL_INV, FLUSH_DONE, SEL_DONE.
- IDLE: flush_req_i=1 -> FLUSH_WALK, set counter <= 0. Else sel_flush_req_i=1 -> SEL_INV, latch set = sel_flush_addr_i[OFFSET_WIDTH+SET_WIDTH-1:OFFSET_WIDTH]. Both high: full flush wins; sel request stays pending.
- FLUSH_WALK: inv_req_o=1, inv_set_o=counter; on inv_gnt_i, counter+1; grant with counter=NB_SETS-1 -> FLUSH_DONE.
- SEL_INV: inv_req_o=1, inv_set_o=latched set; on inv_gnt_i -> SEL_DONE.
- FLUSH_DONE: flush_ack_o=1; flush_req_i=0 -> IDLE. SEL_DONE: sel_flush_ack_o=1; sel_flush_req_i=0 -> IDLE (4-phase).
- lookup_stall_o=1 in FLUSH_WALK and SEL_INV.
- Stats: if clear_regs_i, both counters <= 0 (clear wins over same-cycle increment). Else if enable_regs_i, hit_count += popcount(hit_i), trans_count += popcount(trans_i), modulo 2^32 (wrap, no saturation).

## Timing
- Reset values: bypass_ack_o all 1, cache_bypass_o all 1, flush_ack_o 0, sel_flush_ack_o 0, counters 0, inv_req_o 0, inv_set_o 0, lookup_stall_o 0, FSM IDLE.
- All outputs registered or decoded from registered state; no combinational path from *_req_i to any output.
- Bypass: idle cores follow bypass_req_i 1 cycle later; global bit 1 cycle after last core/refill condition met.
- Full flush with inv_gnt_i tied 1: request sampled cycle 0, inv_req_o cycles 1..NB_SETS, flush_ack_o from cycle NB_SETS+1 until request drops, then IDLE next cycle.
- Selective flush with gnt tied 1: inv_req_o cycle 1, ack cycle 2.
- inv_req_o/inv_set_o held stable until granted.
- Reset mid-flush: immediate return to reset values; partial walk abandoned, no ack.
- Counters: increment visible 1 cycle after event.

## Test plan
- Reset then bypass_req_i=0, cores idle, refill idle -> bypass_ack_o = 9'h000 in 1 cycle (per-core) and global bit cleared 1 cycle later; reverse -> 9'h1FF.
- bypass_req_i=0 with core_busy_i=8'h04 for 5 cycles -> bit 2 and bit 8 stay 1 until busy drops, then clear within 2 cycles.
- Full flush, NB_SETS=64, inv_gnt_i random 50% -> sets 0..63 each invalidated exactly once, in order, flush_ack_o held until req drops, no stall after.
- Selective flush addr 32'h1C00_0A50 -> inv_set_o = 6'h25, sel_flush_ack_o 2 cycles after req (gnt=1); flush and sel asserted together -> full flush first, then selective.
- enable_regs_i=1, hit_i=8'hFF and trans_i=8'hFF for 10 cycles -> both counts 80; clear_regs_i together with events -> 0; preload near 2^32 -> wraps.
- rst_ni asserted at set 20 of a walk -> inv_req_o 0 immediately, FSM IDLE, no ack; new flush after reset completes normally.

Source files
------------

// File: rtl/icache_ctrl_responder.sv
// Cache-side endpoint of the icache control interface: bypass handshake,
// full/selective flush sequencing against the tag array, and hit/transaction statistics.
module icache_ctrl_responder #(
  parameter int NB_CORES     = 8,
  parameter int NB_SETS      = 64,
  parameter int OFFSET_WIDTH = 4,
  parameter int SET_WIDTH    = $clog2(NB_SETS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 bypass_req_i,
  output logic [NB_CORES:0]    bypass_ack_o,
  input  logic                 flush_req_i,
  output logic                 flush_ack_o,
  input  logic                 sel_flush_req_i,
  input  logic [31:0]          sel_flush_addr_i,
  output logic                 sel_flush_ack_o,
  input  logic                 clear_regs_i,
  input  logic                 enable_regs_i,
  output logic [31:0]          hit_count_o,
  output logic [31:0]          trans_count_o,
  input  logic [NB_CORES-1:0]  core_busy_i,
  input  logic                 refill_busy_i,
  input  logic [NB_CORES-1:0]  hit_i,
  input  logic [NB_CORES-1:0]  trans_i,
  output logic [NB_CORES-1:0]  cache_bypass_o,
  output logic                 inv_req_o,
  output logic [SET_WIDTH-1:0] inv_set_o,
  input  logic                 inv_gnt_i,
  output logic                 lookup_stall_o
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] FLUSH_WALK = 3'd1;
  localparam logic [2:0] SEL_INV    = 3'd2;
  localparam logic [2:0] FLUSH_DONE = 3'd3;
  localparam logic [2:0] SEL_DONE   = 3'd4;

  localparam logic [SET_WIDTH-1:0] LAST_SET = SET_WIDTH'(NB_SETS - 1);

  function automatic logic [31:0] popcount(input logic [NB_CORES-1:0] v);
    logic [31:0] c;
    c = 32'd0;
    for (int i = 0; i < NB_CORES; i++) begin
      c = c + {31'd0, v[i]};
    end
    return c;
  endfunction

  logic [NB_CORES:0]    bypass_ack_r;
  logic [2:0]           state_r, state_s;
  logic [SET_WIDTH-1:0] set_r, set_s;
  logic [31:0]          hit_count_r, trans_count_r;
  logic                 unused_addr_s;

  assign unused_addr_s = ^{sel_flush_addr_i[31:OFFSET_WIDTH+SET_WIDTH],
                           sel_flush_addr_i[OFFSET_WIDTH-1:0]};

  // Bypass state: idle cores follow the request; global bit waits for all cores and refill.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bypass_ack_r <= '1;
    end else begin
      for (int i = 0; i < NB_CORES; i++) begin
        if (!core_busy_i[i]) begin
          bypass_ack_r[i] <= bypass_req_i;
        end
      end
      if ((bypass_ack_r[NB_CORES-1:0] == {NB_CORES{bypass_req_i}}) && !refill_busy_i) begin
        bypass_ack_r[NB_CORES] <= bypass_req_i;
      end
    end
  end

  // Flush sequencer next-state; set_r doubles as walk counter and latched selective set.
  always_comb begin
    state_s = state_r;
    set_s   = set_r;
    case (state_r)
      IDLE: begin
        if (flush_req_i) begin
          state_s = FLUSH_WALK;
          set_s   = '0;
        end else if (sel_flush_req_i) begin
          state_s = SEL_INV;
          set_s   = sel_flush_addr_i[OFFSET_WIDTH+SET_WIDTH-1:OFFSET_WIDTH];
        end else begin
          state_s = IDLE;
        end
      end
      FLUSH_WALK: begin
        if (inv_gnt_i) begin
          set_s = set_r + SET_WIDTH'(1);
          if (set_r == LAST_SET) begin
            state_s = FLUSH_DONE;
          end else begin
            state_s = FLUSH_WALK;
          end
        end else begin
          state_s = FLUSH_WALK;
        end
      end
      SEL_INV: begin
        if (inv_gnt_i) begin
          state_s = SEL_DONE;
        end else begin
          state_s = SEL_INV;
        end
      end
      FLUSH_DONE: begin
        if (!flush_req_i) begin
          state_s = IDLE;
        end else begin
          state_s = FLUSH_DONE;
        end
      end
      SEL_DONE: begin
        if (!sel_flush_req_i) begin
          state_s = IDLE;
        end else begin
          state_s = SEL_DONE;
        end
      end
      default: begin
        state_s = IDLE;
        set_s   = '0;
      end
    endcase
  end

  // Flush sequencer state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      set_r   <= '0;
    end else begin
      state_r <= state_s;
      set_r   <= set_s;
    end
  end

  // Statistics counters; clear takes priority over same-cycle events, wrap modulo 2^32.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_count_r   <= 32'd0;
      trans_count_r <= 32'd0;
    end else if (clear_regs_i) begin
      hit_count_r   <= 32'd0;
      trans_count_r <= 32'd0;
    end else if (enable_regs_i) begin
      hit_count_r   <= hit_count_r + popcount(hit_i);
      trans_count_r <= trans_count_r + popcount(trans_i);
    end
  end

  assign bypass_ack_o    = bypass_ack_r;
  assign cache_bypass_o  = bypass_ack_r[NB_CORES-1:0];
  assign inv_req_o       = (state_r == FLUSH_WALK) || (state_r == SEL_INV);
  assign lookup_stall_o  = (state_r == FLUSH_WALK) || (state_r == SEL_INV);
  assign inv_set_o       = set_r;
  assign flush_ack_o     = (state_r == FLUSH_DONE);
  assign sel_flush_ack_o = (state_r == SEL_DONE);
  assign hit_count_o     = hit_count_r;
  assign trans_count_o   = trans_count_r;

endmodule

// File: tb/tb_icache_ctrl_responder.sv
// Directed self-checking bench for icache_ctrl_responder (NB_CORES=8, NB_SETS=64).
module tb_icache_ctrl_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        bypass_req_i;
  logic [8:0]  bypass_ack_o;
  logic        flush_req_i;
  logic        flush_ack_o;
  logic        sel_flush_req_i;
  logic [31:0] sel_flush_addr_i;
  logic        sel_flush_ack_o;
  logic        clear_regs_i;
  logic        enable_regs_i;
  logic [31:0] hit_count_o;
  logic [31:0] trans_count_o;
  logic [7:0]  core_busy_i;
  logic        refill_busy_i;
  logic [7:0]  hit_i;
  logic [7:0]  trans_i;
  logic [7:0]  cache_bypass_o;
  logic        inv_req_o;
  logic [5:0]  inv_set_o;
  logic        inv_gnt_i;
  logic        lookup_stall_o;

  int err_cnt = 0;
  int chk_cnt = 0;

  icache_ctrl_responder dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .bypass_req_i(bypass_req_i), .bypass_ack_o(bypass_ack_o),
    .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o),
    .sel_flush_req_i(sel_flush_req_i), .sel_flush_addr_i(sel_flush_addr_i),
    .sel_flush_ack_o(sel_flush_ack_o),
    .clear_regs_i(clear_regs_i), .enable_regs_i(enable_regs_i),
    .hit_count_o(hit_count_o), .trans_count_o(trans_count_o),
    .core_busy_i(core_busy_i), .refill_busy_i(refill_busy_i),
    .hit_i(hit_i), .trans_i(trans_i),
    .cache_bypass_o(cache_bypass_o),
    .inv_req_o(inv_req_o), .inv_set_o(inv_set_o), .inv_gnt_i(inv_gnt_i),
    .lookup_stall_o(lookup_stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    int idx;
    rst_ni = 1'b0; bypass_req_i = 1'b1; flush_req_i = 1'b0; sel_flush_req_i = 1'b0;
    sel_flush_addr_i = 32'd0; clear_regs_i = 1'b0; enable_regs_i = 1'b0;
    core_busy_i = 8'h00; refill_busy_i = 1'b0; hit_i = 8'h00; trans_i = 8'h00;
    inv_gnt_i = 1'b1;
    step(2);
    rst_ni = 1'b1;
    check("rst_bypass_ack", 32'(bypass_ack_o), 32'h1FF);
    check("rst_cache_bypass", 32'(cache_bypass_o), 32'hFF);
    check("rst_flush_ack", 32'(flush_ack_o), 32'd0);
    check("rst_sel_ack", 32'(sel_flush_ack_o), 32'd0);
    check("rst_hit", hit_count_o, 32'd0);
    check("rst_trans", trans_count_o, 32'd0);
    check("rst_inv_req", 32'(inv_req_o), 32'd0);
    check("rst_inv_set", 32'(inv_set_o), 32'd0);
    check("rst_stall", 32'(lookup_stall_o), 32'd0);

    // Bypass disable/enable with idle cores
    bypass_req_i = 1'b0;
    step(1); check("byp_off_cores", 32'(bypass_ack_o), 32'h100);
    step(1); check("byp_off_global", 32'(bypass_ack_o), 32'h000);
    check("byp_off_cache", 32'(cache_bypass_o), 32'h00);
    bypass_req_i = 1'b1;
    step(1); check("byp_on_cores", 32'(bypass_ack_o), 32'h0FF);
    step(1); check("byp_on_global", 32'(bypass_ack_o), 32'h1FF);

    // Busy core 2 holds its bit and the global bit
    bypass_req_i = 1'b0; core_busy_i = 8'h04;
    for (int i = 0; i < 5; i++) begin
      step(1); check("byp_busy_hold", 32'(bypass_ack_o), 32'h104);
    end
    core_busy_i = 8'h00;
    step(1); check("byp_busy_rel1", 32'(bypass_ack_o), 32'h100);
    step(1); check("byp_busy_rel2", 32'(bypass_ack_o), 32'h000);

    // Refill busy blocks the global bit only
    bypass_req_i = 1'b1; refill_busy_i = 1'b1;
    step(2); check("byp_refill_hold", 32'(bypass_ack_o), 32'h0FF);
    refill_busy_i = 1'b0;
    step(1); check("byp_refill_rel", 32'(bypass_ack_o), 32'h1FF);

    // Statistics
    enable_regs_i = 1'b1; hit_i = 8'hFF; trans_i = 8'hFF;
    step(10);
    check("stat_hit_80", hit_count_o, 32'd80);
    check("stat_trans_80", trans_count_o, 32'd80);
    hit_i = 8'h05; trans_i = 8'h81;
    step(1);
    check("stat_hit_82", hit_count_o, 32'd82);
    check("stat_trans_82", trans_count_o, 32'd82);
    clear_regs_i = 1'b1; hit_i = 8'hFF; trans_i = 8'hFF;
    step(1);
    check("stat_clear_hit", hit_count_o, 32'd0);
    check("stat_clear_trans", trans_count_o, 32'd0);
    clear_regs_i = 1'b0; enable_regs_i = 1'b0;
    step(2);
    check("stat_disabled", hit_count_o, 32'd0);
    force dut.hit_count_r = 32'hFFFF_FFFC;
    force dut.trans_count_r = 32'hFFFF_FFFF;
    #1;
    release dut.hit_count_r;
    release dut.trans_count_r;
    enable_regs_i = 1'b1; hit_i = 8'h0F; trans_i = 8'h03;
    step(1);
    check("stat_wrap_hit", hit_count_o, 32'd0);
    check("stat_wrap_trans", trans_count_o, 32'd1);
    enable_regs_i = 1'b0; hit_i = 8'h00; trans_i = 8'h00;

    // Full flush with random grants: in-order walk, each set once
    flush_req_i = 1'b1;
    step(1);
    idx = 0;
    for (int c = 0; c < 2000 && idx < 64; c++) begin
      check("walk_req", 32'(inv_req_o), 32'd1);
      check("walk_stall", 32'(lookup_stall_o), 32'd1);
      check("walk_set", 32'(inv_set_o), 32'(idx));
      inv_gnt_i = ($urandom_range(0, 1) == 1);
      step(1);
      if (inv_gnt_i) idx++;
    end
    check("walk_count", 32'(idx), 32'd64);
    inv_gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("walk_ack_hold", 32'(flush_ack_o), 32'd1);
      check("walk_no_req", 32'(inv_req_o), 32'd0);
      check("walk_no_stall", 32'(lookup_stall_o), 32'd0);
      step(1);
    end
    flush_req_i = 1'b0;
    step(1); check("walk_ack_drop", 32'(flush_ack_o), 32'd0);

    // Selective flush
    sel_flush_addr_i = 32'h1C00_0A50; sel_flush_req_i = 1'b1;
    step(1);
    check("sel_req", 32'(inv_req_o), 32'd1);
    check("sel_set", 32'(inv_set_o), 32'h25);
    check("sel_stall", 32'(lookup_stall_o), 32'd1);
    step(1);
    check("sel_ack", 32'(sel_flush_ack_o), 32'd1);
    check("sel_req_off", 32'(inv_req_o), 32'd0);
    sel_flush_req_i = 1'b0;
    step(1); check("sel_ack_drop", 32'(sel_flush_ack_o), 32'd0);

    // Both requests together: full flush first, then selective
    sel_flush_addr_i = 32'h0000_03F0; flush_req_i = 1'b1; sel_flush_req_i = 1'b1;
    step(1); check("both_first_set", 32'(inv_set_o), 32'd0);
    step(63); check("both_last_set", 32'(inv_set_o), 32'd63);
    check("both_last_req", 32'(inv_req_o), 32'd1);
    step(1);
    check("both_flush_ack", 32'(flush_ack_o), 32'd1);
    check("both_sel_pending", 32'(sel_flush_ack_o), 32'd0);
    flush_req_i = 1'b0;
    step(1); check("both_idle", 32'(inv_req_o), 32'd0);
    step(1);
    check("both_sel_req", 32'(inv_req_o), 32'd1);
    check("both_sel_set", 32'(inv_set_o), 32'h3F);
    step(1); check("both_sel_ack", 32'(sel_flush_ack_o), 32'd1);
    sel_flush_req_i = 1'b0;
    step(1); check("both_sel_drop", 32'(sel_flush_ack_o), 32'd0);

    // Reset in the middle of a walk
    flush_req_i = 1'b1;
    step(21); check("mid_set20", 32'(inv_set_o), 32'd20);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_req", 32'(inv_req_o), 32'd0);
    check("mid_rst_set", 32'(inv_set_o), 32'd0);
    check("mid_rst_stall", 32'(lookup_stall_o), 32'd0);
    check("mid_rst_ack", 32'(flush_ack_o), 32'd0);
    step(1);
    check("mid_rst_hold", 32'(inv_req_o), 32'd0);
    rst_ni = 1'b1;
    step(1); check("re_first", 32'(inv_set_o), 32'd0);
    check("re_req", 32'(inv_req_o), 32'd1);
    step(63); check("re_last", 32'(inv_set_o), 32'd63);
    step(1); check("re_ack", 32'(flush_ack_o), 32'd1);
    flush_req_i = 1'b0;
    step(1); check("re_ack_drop", 32'(flush_ack_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
